// File: rtl/tdm_pkg.sv
// Shared framing definitions for the TDM link (sender and receiver agree on these).
// Optional feature macro: PARITY_CHECK_EN adds one even-parity slot after the data slots.
package tdm_pkg;

    // Receiver FSM encoding
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned SLOTS_DEF       = 4;
    localparam int unsigned SLOT_CYCLES_DEF = 8;
    localparam int unsigned SLOT_IDX_W      = 2;

    // Parity slot: when present it follows the last data slot and carries even parity
    // over the data slots (XOR of data and parity bits is 0).
`ifdef PARITY_CHECK_EN
    localparam int unsigned PARITY_SLOTS = 1;
`else
    localparam int unsigned PARITY_SLOTS = 0;
`endif

    // Total slots per frame for a given number of data slots
    function automatic int unsigned frame_slots(input int unsigned slots);
        return slots + PARITY_SLOTS;
    endfunction

endpackage

// File: rtl/tdm_demux4_if.sv
// TDM link bundle between the sender side and the tdm_demux4 receiver.
//   SER_IN, SYNC                          : serial data and frame-start strobe (sender -> receiver)
//   PAR_OUT, PAR_VALID, SLOT_IDX,
//   SYNC_ERR, PAR_ERR                     : decoded word and status (receiver -> consumer)
// Modports: master = sender/consumer side, slave = receiver.
interface tdm_demux4_if
    import tdm_pkg::*;
#(
    parameter int unsigned SLOTS = SLOTS_DEF
);

    logic                  SER_IN;
    logic                  SYNC;
    logic [SLOTS-1:0]      PAR_OUT;
    logic                  PAR_VALID;
    logic [SLOT_IDX_W-1:0] SLOT_IDX;
    logic                  SYNC_ERR;
    logic                  PAR_ERR;

    modport master (
        output SER_IN,
        output SYNC,
        input  PAR_OUT,
        input  PAR_VALID,
        input  SLOT_IDX,
        input  SYNC_ERR,
        input  PAR_ERR
    );

    modport slave (
        input  SER_IN,
        input  SYNC,
        output PAR_OUT,
        output PAR_VALID,
        output SLOT_IDX,
        output SYNC_ERR,
        output PAR_ERR
    );

endinterface

// File: rtl/tdm_slot_timer.sv
// Frame timing for the TDM receiver: phase-within-slot and slot counters, mid-slot sample
// strobe, end-of-frame flag and the registered (saturated) slot index for display.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset
//   active_i    : receiver is inside a frame (RUN)
//   restart_i   : SYNC seen this cycle; this cycle is frame cycle 0
//   sample_c_o  : sample SER_IN into slot slot_c_o this cycle
//   eof_c_o     : this cycle is the last cycle of the frame
//   slot_c_o    : current slot number (including parity slot)
//   slot_idx_o  : registered slot number, saturated at SLOTS-1, 0 when idle
module tdm_slot_timer
    import tdm_pkg::*;
#(
    parameter int unsigned SLOTS       = SLOTS_DEF,
    parameter int unsigned NS          = SLOTS_DEF,
    parameter int unsigned SLOT_CYCLES = SLOT_CYCLES_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       active_i,
    input  logic                       restart_i,
    output logic                       sample_c_o,
    output logic                       eof_c_o,
    output logic [$clog2(NS)-1:0]      slot_c_o,
    output logic [SLOT_IDX_W-1:0]      slot_idx_o
);

    localparam int unsigned PH_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int unsigned SL_W = $clog2(NS);

    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(SLOT_CYCLES - 1);
    localparam logic [PH_W-1:0] PH_MID    = PH_W'(SLOT_CYCLES / 2);
    localparam logic [SL_W-1:0] SL_LAST   = SL_W'(NS - 1);
    localparam logic [SL_W-1:0] DATA_LAST = SL_W'(SLOTS - 1);

    logic [PH_W-1:0]       phase_q, phase_d;
    logic [SL_W-1:0]       slot_q, slot_d;
    logic [SLOT_IDX_W-1:0] slot_idx_q, slot_idx_d;

    // Frame position decode; a SYNC cycle is always c=0, so never a sample point
    assign eof_c_o    = active_i && (slot_q == SL_LAST) && (phase_q == PH_LAST);
    assign sample_c_o = active_i && !restart_i && (phase_q == PH_MID);
    assign slot_c_o   = slot_q;
    assign slot_idx_o = slot_idx_q;

    // Counter advance: SYNC makes the next cycle c=1; counters idle at 0 outside a frame
    always_comb begin
        phase_d    = '0;
        slot_d     = '0;
        slot_idx_d = '0;
        if (restart_i) begin
            phase_d = PH_W'(1);
        end else if (active_i && !eof_c_o) begin
            if (phase_q == PH_LAST) begin
                slot_d = slot_q + SL_W'(1);
            end else begin
                phase_d = phase_q + PH_W'(1);
                slot_d  = slot_q;
            end
        end
        // Parity slot shows as the last data slot
        if (slot_d > DATA_LAST) begin
            slot_idx_d = SLOT_IDX_W'(DATA_LAST);
        end else begin
            slot_idx_d = SLOT_IDX_W'(slot_d);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q    <= '0;
            slot_q     <= '0;
            slot_idx_q <= '0;
        end else begin
            phase_q    <= phase_d;
            slot_q     <= slot_d;
            slot_idx_q <= slot_idx_d;
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// Receive end of the TDM switch link: samples SER_IN mid-slot, rebuilds the parallel word,
// and reports SYNC framing errors (and parity errors when PARITY_CHECK_EN is defined).
//   MAX10_CLK1_50 : system clock, rising edge
//   RESET         : synchronous active-high reset
//   link (slave)  : SER_IN/SYNC in; PAR_OUT/PAR_VALID/SLOT_IDX/SYNC_ERR/PAR_ERR out
// Optional feature macro: PARITY_CHECK_EN (extra even-parity slot, PAR_ERR active).
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int unsigned SLOTS       = SLOTS_DEF,
    parameter int unsigned SLOT_CYCLES = SLOT_CYCLES_DEF
) (
    input  logic         MAX10_CLK1_50,
    input  logic         RESET,
    tdm_demux4_if.slave  link
);

    localparam int unsigned NS   = frame_slots(SLOTS);
    localparam int unsigned SL_W = $clog2(NS);

    state_e                state_q, state_d;
    logic                  active;
    logic                  sample_c;
    logic                  eof_c;
    logic [SL_W-1:0]       slot_c;
    logic [SLOT_IDX_W-1:0] slot_idx;

    logic [NS-1:0]         samp_q, samp_d;
    logic [SLOTS-1:0]      par_out_q, par_out_d;
    logic                  par_valid_q, par_valid_d;
    logic                  sync_err_q, sync_err_d;

    assign active = (state_q == ST_RUN);

    tdm_slot_timer #(
        .SLOTS       (SLOTS),
        .NS          (NS),
        .SLOT_CYCLES (SLOT_CYCLES)
    ) u_timer (
        .clk_i      (MAX10_CLK1_50),
        .rst_i      (RESET),
        .active_i   (active),
        .restart_i  (link.SYNC),
        .sample_c_o (sample_c),
        .eof_c_o    (eof_c),
        .slot_c_o   (slot_c),
        .slot_idx_o (slot_idx)
    );

    // FSM state register
    always_ff @(posedge MAX10_CLK1_50) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; SYNC on the last frame cycle chains straight into the next frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (link.SYNC) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (eof_c && !link.SYNC) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef PARITY_CHECK_EN
    logic par_err_q, par_err_d;
    logic parity_ok;

    // Even parity: data bits plus parity bit XOR to zero
    assign parity_ok = ~(^samp_q);
`endif

    // Sample register and output next values
    always_comb begin
        samp_d      = samp_q;
        par_out_d   = par_out_q;
        par_valid_d = 1'b0;
        sync_err_d  = 1'b0;
`ifdef PARITY_CHECK_EN
        par_err_d   = 1'b0;
`endif
        if (link.SYNC) begin
            samp_d = '0;
        end else if (sample_c) begin
            samp_d[slot_c] = link.SER_IN;
        end

        if (eof_c) begin
`ifdef PARITY_CHECK_EN
            if (parity_ok) begin
                par_out_d   = samp_q[SLOTS-1:0];
                par_valid_d = 1'b1;
            end else begin
                par_err_d   = 1'b1;
            end
`else
            par_out_d   = samp_q[SLOTS-1:0];
            par_valid_d = 1'b1;
`endif
        end else if (active && link.SYNC) begin
            // Early SYNC aborts the partial frame; PAR_OUT keeps the last good word
            sync_err_d = 1'b1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge MAX10_CLK1_50) begin
        if (RESET) begin
            samp_q      <= '0;
            par_out_q   <= '0;
            par_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            samp_q      <= samp_d;
            par_out_q   <= par_out_d;
            par_valid_q <= par_valid_d;
            sync_err_q  <= sync_err_d;
`ifdef PARITY_CHECK_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign link.PAR_OUT   = par_out_q;
    assign link.PAR_VALID = par_valid_q;
    assign link.SLOT_IDX  = slot_idx;
    assign link.SYNC_ERR  = sync_err_q;
`ifdef PARITY_CHECK_EN
    assign link.PAR_ERR   = par_err_q;
`else
    assign link.PAR_ERR   = 1'b0;
`endif

endmodule
